// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: two-to-one Avalon arbiter (port 0 = ibus, port 1 = dbus)
// sharing one memory port, with stall lock, outstanding-read limit and
// in-order response routing through an owner FIFO.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention;
// otherwise dbus has fixed priority on contention.

package avalon_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byte_enable;
    } avalon_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] readdata;
        logic              readdatavalid;
        logic              waitrequest;
    } avalon_resp_t;

endpackage

module avalon_bus_arbiter
    import avalon_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  avalon_req_t  ibus_avalon_req,
    output avalon_resp_t ibus_avalon_resp,
    input  avalon_req_t  dbus_avalon_req,
    output avalon_resp_t dbus_avalon_resp,
    output avalon_req_t  mem_avalon_req,
    input  avalon_resp_t mem_avalon_resp,
    output logic         arb_resp_error
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t                lock_state_q, lock_state_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       resp_err_q, resp_err_d;

    logic [1:0]  req_valid;
    logic        lock_hold;
    logic        win_id;
    logic        win_valid;
    avalon_req_t win_req;
    logic        win_read;
    logic        win_write;
    logic        fifo_full;
    logic        blocked;
    logic        accept;
    logic        push;
    logic        pop;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
`endif

    // Pick the winner: a live lock wins, then contention policy, then lone requester.
    always_comb begin
        req_valid[0] = ibus_avalon_req.read | ibus_avalon_req.write;
        req_valid[1] = dbus_avalon_req.read | dbus_avalon_req.write;
        lock_hold    = (lock_state_q == LOCKED) && req_valid[lock_id_q];
        win_valid    = |req_valid;
        win_id       = 1'b0;
        if (lock_hold) begin
            win_id = lock_id_q;
        end else if (&req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_id = ~last_grant_q;
`else
            win_id = 1'b1;
`endif
        end else begin
            win_id = req_valid[1];
        end
        win_req = win_id ? dbus_avalon_req : ibus_avalon_req;
    end

    // Qualify the winner's transfer: reads win over writes, reads block when the FIFO is full.
    always_comb begin
        win_read  = win_valid & win_req.read;
        win_write = win_valid & win_req.write & ~win_req.read;
        fifo_full = (count_q == CNT_W'(MAX_OUTSTANDING));
        blocked   = win_read & fifo_full;
        accept    = win_valid & ~blocked & ~mem_avalon_resp.waitrequest;
        push      = accept & win_read;
        pop       = mem_avalon_resp.readdatavalid & (count_q != '0);
    end

    // Forward the winner downstream; idle fields are driven to zero.
    always_comb begin
        mem_avalon_req = '0;
        if (win_valid) begin
            mem_avalon_req.address     = win_req.address;
            mem_avalon_req.writedata   = win_req.writedata;
            mem_avalon_req.byte_enable = win_req.byte_enable;
            mem_avalon_req.read        = win_read & ~blocked;
            mem_avalon_req.write       = win_write;
        end
    end

    // Upstream responses: stall losers and blocked winners, route read data to the FIFO head owner.
    always_comb begin
        ibus_avalon_resp               = '0;
        dbus_avalon_resp               = '0;
        ibus_avalon_resp.readdata      = mem_avalon_resp.readdata;
        dbus_avalon_resp.readdata      = mem_avalon_resp.readdata;
        ibus_avalon_resp.readdatavalid = pop & ~owner_q[0];
        dbus_avalon_resp.readdatavalid = pop & owner_q[0];
        ibus_avalon_resp.waitrequest   = req_valid[0] &
                                         (win_id | blocked | mem_avalon_resp.waitrequest);
        dbus_avalon_resp.waitrequest   = req_valid[1] &
                                         (~win_id | blocked | mem_avalon_resp.waitrequest);
    end

    // Lock next state: hold a stalled grant until it is accepted or its requester gives up.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_id_d    = lock_id_q;
        case (lock_state_q)
            UNLOCKED: begin
                if (win_valid && mem_avalon_resp.waitrequest) begin
                    lock_state_d = LOCKED;
                    lock_id_d    = win_id;
                end
            end
            LOCKED: begin
                if (!lock_hold) begin
                    // Locked port dropped its request: re-evaluate as if unlocked.
                    if (win_valid && mem_avalon_resp.waitrequest) begin
                        lock_state_d = LOCKED;
                        lock_id_d    = win_id;
                    end else begin
                        lock_state_d = UNLOCKED;
                    end
                end else if (accept) begin
                    lock_state_d = UNLOCKED;
                end
            end
            default: lock_state_d = UNLOCKED;
        endcase
    end

    // Owner FIFO as a shift register (head at bit 0) plus sticky orphan-response error.
    always_comb begin
        owner_d    = owner_q;
        count_d    = count_q;
        resp_err_d = resp_err_q;
        if (pop) begin
            owner_d = owner_q >> 1;
            count_d = count_q - CNT_W'(1);
        end
        if (push) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (CNT_W'(i) == count_d) begin
                    owner_d[i] = win_id;
                end
            end
            count_d = count_d + CNT_W'(1);
        end
        if (mem_avalon_resp.readdatavalid && (count_q == '0)) begin
            resp_err_d = 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer moves only on an accepted transfer.
    always_comb begin
        last_grant_d = accept ? win_id : last_grant_q;
    end

    // Round-robin pointer register; port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_q <= UNLOCKED;
            lock_id_q    <= 1'b0;
            owner_q      <= '0;
            count_q      <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_id_q    <= lock_id_d;
            owner_q      <= owner_d;
            count_q      <= count_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign arb_resp_error = resp_err_q;

endmodule

// File: doc/avalon_bus_arbiter.md
# avalon_bus_arbiter

Two-to-one Avalon arbiter that shares a single memory port between the instruction bus (port 0) and the load/store data bus (port 1). It grants one requester per cycle, holds the grant stable while the downstream slave stalls, tracks outstanding reads in an in-order owner FIFO, and routes each returning read response to the port that issued the read. It sits between the core's ibus/dbus and the on-chip memory or interconnect.

## Interface
- MAX_OUTSTANDING, 2, owner-FIFO depth: maximum accepted reads awaiting readdatavalid; power of 2, at least 1.

- clk  input  1  clock
- rst  input  1  reset rst, synchronous, active-high; clock clk
- ibus_avalon_req  input  avalon_req_t  port 0 request (read, write, address, writedata, byte_enable)
- ibus_avalon_resp  output  avalon_resp_t  port 0 response (readdata, readdatavalid, waitrequest)
- dbus_avalon_req  input  avalon_req_t  port 1 request
- dbus_avalon_resp  output  avalon_resp_t  port 1 response
- mem_avalon_req  output  avalon_req_t  shared downstream request
- mem_avalon_resp  input  avalon_resp_t  shared downstream response
- arb_resp_error  output  1  sticky; set when downstream readdatavalid arrives with an empty owner FIFO

## Operation
- Request valid for port p: req.read | req.write. A request with both bits set is treated as a read.
- Arbitration selects the winner combinationally each cycle.
  - A single requester wins.
  - On contention, the winner comes from the policy in Configuration.
- Lock:
  - The lock register is set when a granted request sees mem waitrequest = 1.
  - While locked, the grant stays on the locked port regardless of the other port.
  - The lock clears in the cycle the locked request is accepted.
  - The lock also clears if the locked port drops its request, which is a protocol violation but still handled.
- Read blocking: reads are blocked when the owner FIFO holds MAX_OUTSTANDING entries. A blocked read is not forwarded: mem read = 0 and the port sees waitrequest = 1. Writes are never blocked by the FIFO.
- Forwarding: the winner's address, writedata, byte_enable, read and write are driven onto mem_avalon_req, with read/write gated by blocking. With no winner, mem read and write are 0 and the other fields are don't-care (driven 0).
- Accept: winner valid, not blocked, and mem waitrequest = 0.
  - An accepted read pushes the winner id (0/1) into the owner FIFO.
  - Accepted writes push nothing.
- Upstream waitrequest:
  - Equals 1 for the losing port and for a blocked winner.
  - Otherwise equals mem waitrequest for the winner.
  - Equals 0 for a port with no request.
- Response routing:
  - On mem readdatavalid with a non-empty FIFO, the head entry is popped.
  - readdata is driven to both ports; readdatavalid goes only to the head owner.
  - With an empty FIFO the response is dropped and arb_resp_error is set.
- Simultaneous push and pop in the same cycle: allowed, and the count is unchanged. When full, the pop does not unblock a read in the same cycle; blocking uses the registered count.

## Timing
- Request path is zero-latency (combinational), and so is response routing. The arbiter adds no cycles; read latency equals the downstream latency.
- The round-robin pointer and the lock update on the clock edge after acceptance or a stall.
- Reset values:
  - owner FIFO empty, count 0
  - lock 0
  - round-robin last-grant = port 1, so port 0 wins the first contention
  - arb_resp_error 0
  - all readdatavalid 0
  - mem read/write follow the inputs combinationally
- Reset with reads in flight: the FIFO is cleared. Later responses for those reads are dropped and set arb_resp_error; the bench must not treat this as a failure.
- The ibus_avalon_resp/dbus_avalon_resp waitrequest relationship to mem waitrequest holds in every cycle, including under reset.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention, grant the port not granted by the last accepted transfer. The pointer updates only on accept, so a stalled grant does not rotate.
- Not defined: fixed priority, where port 1 (dbus) always wins contention and the pointer logic is removed. The lock still applies, so a stalled ibus transfer is not pre-empted by dbus.

## Test plan
- Single-port reads: ibus reads 0x100, 0x104 back-to-back with 1-cycle memory latency → mem accepts both in consecutive cycles; ibus readdatavalid in the cycles after, with the data in order; dbus readdatavalid stays 0.
- Contention with ARB_ROUND_ROBIN_EN: both ports read every cycle for 6 cycles → grants alternate 0,1,0,1,0,1. Without the macro → dbus is granted all 6 cycles and ibus sees waitrequest = 1 throughout.
- Lock under stall: ibus read 0x200 granted while mem waitrequest = 1 for 3 cycles, and dbus asserts a write in cycle 2 → the mem request stays 0x200/read for all 3 cycles; dbus is accepted only after the ibus accept.
- Outstanding limit, MAX_OUTSTANDING = 2, memory latency 4: dbus issues 3 reads → the 3rd sees waitrequest = 1 and mem read = 0 until the first readdatavalid. A dbus write issued meanwhile is accepted immediately.
- Interleaved routing: accepted reads in order ibus, dbus, ibus with data A, B, C → readdatavalid goes to ibus (A), dbus (B), ibus (C).
- Reset mid-flight: 2 reads outstanding, rst for 1 cycle, then 2 stray readdatavalid pulses → no upstream readdatavalid and arb_resp_error = 1; after a new rst, arb_resp_error = 0.
